// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared state encoding and constants for the instruction fetch unit
package ifetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_e;
  localparam logic [4:0] HALT_PREFIX = 5'b11111;
  localparam int IFETCH_INSTR_W = 9;
  localparam int IFETCH_PC_W = 10;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: ROM bus, decoder handshake and branch redirect between fetch unit and its environment
interface instr_fetch_if
  import ifetch_pkg::*;
#(
  parameter int PC_W = IFETCH_PC_W,
  parameter int INSTR_W = IFETCH_INSTR_W
);
  logic imem_rd_en;
  logic [PC_W-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr_out;
  logic instr_valid;
  logic instr_ready;
  logic branch_taken;
  logic [PC_W-1:0] branch_target;
  logic done;
  modport master (
    output imem_rd_en, imem_addr, instr_out, instr_valid, done,
    input imem_rdata, instr_ready, branch_taken, branch_target
  );
  modport slave (
    input imem_rd_en, imem_addr, instr_out, instr_valid, done,
    output imem_rdata, instr_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: 2-entry prefetch FIFO with flush; head reads as zero when empty
module ifetch_queue #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic rp, wp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rp <= 1'b0;
      wp <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      rp <= 1'b0;
      wp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wp] <= din;
  assign head = (count != 2'd0) ? mem[rp] : '0;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, run/halt FSM and branch redirect feeding a 2-entry prefetch queue.
// Defining IFETCH_PERF_EN adds saturating retired_cnt/stall_cnt outputs.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int PC_W = IFETCH_PC_W,
  parameter int INSTR_W = IFETCH_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst_n,
  input logic start,
  instr_fetch_if.master bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0] retired_cnt,
  output logic [15:0] stall_cnt
`endif
);
  fetch_state_e state, state_nx;
  logic [PC_W-1:0] pc;
  logic [1:0] count;
  logic inflight, done_q, go, xfer, halt_w, halt_xfer, redirect, flush, push, issue;
  assign go = start && (state != RUN);
  assign xfer = bus.instr_valid && bus.instr_ready;
  assign halt_w = bus.instr_out[INSTR_W-1 -: 5] == HALT_PREFIX;
  assign halt_xfer = xfer && halt_w;
  assign redirect = xfer && (halt_w || bus.branch_taken);
  assign flush = go || redirect;
  // data of a read issued last cycle is dropped if the stream is redirected now
  assign push = inflight && !flush;
  // a word leaving this cycle frees its slot, which keeps the stream at one word per cycle
  assign issue = (state == RUN) && !redirect &&
                 (({1'b0, count} + {2'b0, inflight} - {2'b0, xfer}) < 3'd2);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = go ? RUN : ((state == RUN) && halt_xfer) ? HALT : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      inflight <= 1'b0;
      done_q <= 1'b0;
    end else begin
      pc <= go ? RESET_PC : (redirect && !halt_w) ? bus.branch_target : issue ? pc + 1'b1 : pc;
      inflight <= issue;
      done_q <= go ? 1'b0 : ((state == RUN) && halt_xfer) ? 1'b1 : done_q;
    end
  ifetch_queue #(.W(INSTR_W)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (xfer),
    .flush (flush),
    .din   (bus.imem_rdata),
    .head  (bus.instr_out),
    .count (count)
  );
  assign bus.instr_valid = count != 2'd0;
  assign bus.imem_rd_en = issue;
  assign bus.imem_addr = pc;
  assign bus.done = done_q;
`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      retired_cnt <= '0;
      stall_cnt <= '0;
    end else if (go) begin
      retired_cnt <= '0;
      stall_cnt <= '0;
    end else if (state == RUN) begin
      if (xfer && retired_cnt != '1) retired_cnt <= retired_cnt + 16'd1;
      if (!xfer && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule
